// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU sequencer: opcodes, FSM state type and
// instruction field positions.
package alu_seq_pkg;

    localparam logic [2:0] OP_FWD  = 3'd0;
    localparam logic [2:0] OP_ADD  = 3'd1;
    localparam logic [2:0] OP_SUB  = 3'd2;
    localparam logic [2:0] OP_NOT  = 3'd3;
    localparam logic [2:0] OP_OR   = 3'd4;
    localparam logic [2:0] OP_AND  = 3'd5;
    localparam logic [2:0] OP_XOR  = 3'd6;
    localparam logic [2:0] OP_SHL2 = 3'd7;

    localparam int unsigned REG_AW = 2;

    localparam int unsigned OPC_MSB = 7;
    localparam int unsigned OPC_LSB = 5;
    localparam int unsigned RD_MSB  = 4;
    localparam int unsigned RD_LSB  = 3;
    localparam int unsigned RS_MSB  = 2;
    localparam int unsigned RS_LSB  = 1;
    localparam int unsigned WB_BIT  = 0;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StIssue   = 2'd1,
        StCapture = 2'd2
    } state_e;

endpackage

// File: rtl/alu_seq_regfile.sv
// Register file for the ALU sequencer: two asynchronous read ports, an external
// write port and a writeback port; writeback wins on an address collision.
module alu_seq_regfile
    import alu_seq_pkg::*;
#(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned NREGS  = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [REG_AW-1:0] i_raddr_a,
    output logic [DATA_W-1:0] o_rdata_a,
    input  logic [REG_AW-1:0] i_raddr_b,
    output logic [DATA_W-1:0] o_rdata_b,
    input  logic              i_ext_en,
    input  logic [REG_AW-1:0] i_ext_addr,
    input  logic [DATA_W-1:0] i_ext_data,
    input  logic              i_wb_en,
    input  logic [REG_AW-1:0] i_wb_addr,
    input  logic [DATA_W-1:0] i_wb_data
);

    logic [DATA_W-1:0] r_regs [NREGS];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (i_wb_en && (i_wb_addr == REG_AW'(i))) begin
                    r_regs[i] <= i_wb_data;
                end else if (i_ext_en && (i_ext_addr == REG_AW'(i))) begin
                    r_regs[i] <= i_ext_data;
                end
            end
        end
    end

    // Addresses beyond NREGS read as zero when the file is built shallower than 4.
    always_comb begin
        o_rdata_a = '0;
        o_rdata_b = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (i_raddr_a == REG_AW'(i)) o_rdata_a = r_regs[i];
            if (i_raddr_b == REG_AW'(i)) o_rdata_b = r_regs[i];
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// Three-state sequencer feeding a registered downstream ALU from a small register
// file. Define ALU_SEQ_ZERO_FLAG_EN to build the result-was-zero flag register.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned NREGS  = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [7:0]        i_instr,
    input  logic              i_instr_valid,
    output logic              o_instr_ready,
    input  logic              i_wr_en,
    input  logic [1:0]        i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic              o_alu_en,
    output logic [2:0]        o_alu_opcode,
    output logic [DATA_W-1:0] o_alu_in_1,
    output logic [DATA_W-1:0] o_alu_in_2,
    input  logic [DATA_W-1:0] i_alu_result,
    output logic              o_done,
    output logic [DATA_W-1:0] o_result,
    output logic              o_zero_flag
);

    state_e            r_state;
    state_e            w_state_d;
    logic              w_latch;
    logic              w_capture;
    logic [2:0]        r_opcode;
    logic [1:0]        r_rd;
    logic              r_wb;
    logic [DATA_W-1:0] r_op_a;
    logic [DATA_W-1:0] r_op_b;
    logic [DATA_W-1:0] r_result;
    logic [DATA_W-1:0] w_rdata_a;
    logic [DATA_W-1:0] w_rdata_b;

    alu_seq_regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_regfile (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_raddr_a  (i_instr[RD_MSB:RD_LSB]),
        .o_rdata_a  (w_rdata_a),
        .i_raddr_b  (i_instr[RS_MSB:RS_LSB]),
        .o_rdata_b  (w_rdata_b),
        .i_ext_en   (i_wr_en),
        .i_ext_addr (i_wr_addr),
        .i_ext_data (i_wr_data),
        .i_wb_en    (w_capture && r_wb),
        .i_wb_addr  (r_rd),
        .i_wb_data  (i_alu_result)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= StIdle;
        else          r_state <= w_state_d;
    end

    always_comb begin
        w_state_d     = r_state;
        o_instr_ready = 1'b0;
        o_alu_en      = 1'b0;
        w_capture     = 1'b0;
        w_latch       = 1'b0;
        unique case (r_state)
            StIdle: begin
                o_instr_ready = 1'b1;
                if (i_instr_valid) begin
                    w_latch   = 1'b1;
                    w_state_d = StIssue;
                end
            end
            StIssue: begin
                o_alu_en  = 1'b1;
                w_state_d = StCapture;
            end
            StCapture: begin
                w_capture = 1'b1;
                w_state_d = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

    // Operands are snapshotted at acceptance, so later external writes cannot leak in.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_opcode <= '0;
            r_rd     <= '0;
            r_wb     <= 1'b0;
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_result <= '0;
        end else begin
            if (w_latch) begin
                r_opcode <= i_instr[OPC_MSB:OPC_LSB];
                r_rd     <= i_instr[RD_MSB:RD_LSB];
                r_wb     <= i_instr[WB_BIT];
                r_op_a   <= w_rdata_a;
                r_op_b   <= w_rdata_b;
            end
            if (w_capture) r_result <= i_alu_result;
        end
    end

    assign o_alu_opcode = r_opcode;
    assign o_alu_in_1   = r_op_a;
    assign o_alu_in_2   = r_op_b;
    assign o_done       = w_capture;
    assign o_result     = w_capture ? i_alu_result : r_result;

`ifdef ALU_SEQ_ZERO_FLAG_EN
    logic r_zero_flag;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)       r_zero_flag <= 1'b0;
        else if (w_capture) r_zero_flag <= (i_alu_result == '0);
    end

    assign o_zero_flag = r_zero_flag;
`else
    assign o_zero_flag = 1'b0;
`endif

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter: DATA_W, 4, operand/result width; SHALL equal the ALU operand width.
REQ-002 Parameter: NREGS, 4, register-file depth; SHALL be a power of two, at most 4 (2-bit register fields).
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous and active-low.
REQ-005 instr  in  8  instruction: [7:5] opcode, [4:3] rd (also in_1 source), [2:1] rs (in_2 source), [0] wb (1 = write result to rd).
REQ-006 instr_valid  in  1 / instr_ready  out  1  instruction handshake; a transfer occurs on a clock edge where both are 1.
REQ-007 wr_en  in  1 / wr_addr  in  2 / wr_data  in  DATA_W  external register load port.
REQ-008 alu_en  out  1 / alu_opcode  out  3 / alu_in_1, alu_in_2  out  DATA_W  drive the downstream ALU.
REQ-009 alu_result  in  DATA_W  registered ALU output, valid one cycle after the ALU samples alu_en=1.
REQ-010 done  out  1 / result  out  DATA_W  one-cycle completion pulse with the captured result.
REQ-011 zero_flag  out  1  result-was-zero flag (see Configuration).

Function
REQ-012 FSM states SHALL be IDLE, ISSUE, CAPTURE; no other states.
REQ-013 IDLE: instr_ready=1; on transfer, latch opcode, rd, wb, and the values of regs[rd] and regs[rs]; go to ISSUE.
REQ-014 ISSUE: alu_en=1, alu_opcode and alu_in_1/alu_in_2 from latched values; next state CAPTURE, unconditionally.
REQ-015 CAPTURE: done=1, result=alu_result; if wb=1, write alu_result to regs[rd] at the closing edge; next state IDLE.
REQ-016 Latency: transfer at edge N; done high in the cycle after edge N+1; one instruction per 3 cycles maximum.
REQ-017 instr_ready SHALL be 0 in ISSUE and CAPTURE; alu_en SHALL be 0 outside ISSUE.
REQ-018 Operands latched at acceptance; external writes during ISSUE/CAPTURE SHALL NOT change the issued operands.
REQ-019 External write SHALL be accepted in any state.
REQ-020 Simultaneous external write and CAPTURE writeback to the same register: writeback SHALL win; different registers: both SHALL occur.
REQ-021 Transfer in IDLE with simultaneous wr_en to a source register: the pre-edge register value SHALL be latched.
REQ-022 result SHALL hold its last value outside CAPTURE; arithmetic wraps modulo 2^DATA_W (performed by ALU).

Reset
REQ-023 rst_n=0 SHALL immediately force state IDLE, all registers 0, alu_en 0, alu_opcode 0, alu_in_1/2 0, done 0, result 0, zero_flag 0.
REQ-024 Reset asserted during ISSUE or CAPTURE SHALL abort the instruction with no writeback and no done pulse.
REQ-025 After rst_n deasserts, instr_ready SHALL be 1 in the first cycle.

Configuration
REQ-026 Macro ALU_SEQ_ZERO_FLAG_EN defined: zero_flag SHALL update at the CAPTURE closing edge to (alu_result==0), regardless of wb, and hold otherwise.
REQ-027 Macro not defined: zero_flag port SHALL remain present and tied to 0; no flag register SHALL be built.

Structure
REQ-028 Package alu_seq_pkg SHALL hold the opcode localparams (FWD, ADD, SUB, NOT, OR, AND, XOR, SHL2 = 0..7), the FSM state typedef, and instr field bit positions.
REQ-029 Register file SHALL be a sub-module alu_seq_regfile: two async read ports, two write ports with the REQ-020 priority.

Verification
REQ-030 Load r0=3, r1=5 via wr port; instr {ADD,rd=0,rs=1,wb=1} -> done after 2 cycles, result=8, r0=8.
REQ-031 r0=2, r1=3; {SUB,0,1,wb=0} -> result=F (wrap), r0 stays 2; with macro zero_flag=0.
REQ-032 r2=5; {XOR,2,2,wb=1} -> result=0, r2=0, zero_flag=1 with macro, 0 without.
REQ-033 instr_valid held high for 3 instructions -> instr_ready low 2 of every 3 cycles, exactly 3 done pulses.
REQ-034 In CAPTURE of {FWD,1,..,wb=1} with r1=7, wr_en to r1 with A -> r1=7; same cycle wr to r3 with A -> r3=A.
REQ-035 rst_n low during ISSUE -> alu_en drops immediately, no done, all regs 0, instr_ready=1 after release.
